pico_issue_ctrl: RTL and testbench



---
 rtl/pico_issue_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pico_issue_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pico_issue_ctrl.sv
// pico_issue_ctrl: instruction issue sequencer between the pin-level loader and the
// 8-bit pico RISC-V core. Buffers 16-bit words in a DEPTH-entry FIFO and issues one at
// a time, waiting for the core's completion strobe before the next issue.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid_i, in_instr_i     loader offers a word
//   in_ready_o                 FIFO accepts a word this cycle
//   issue_valid_o/issue_instr_o head word offered to the core
//   issue_ready_i              core accepts the offered word
//   core_done_i                one-cycle retire strobe (only honoured in WAIT)
//   core_branch_taken_i        qualified by core_done_i; may flush the queue
//   busy_o                     sequencer active or FIFO non-empty
//   flush_pulse_o              one-cycle strobe while the queue is discarded
//   fifo_count_o               current occupancy
//   issued_cnt_o               retired-instruction counter, wraps at 256
//   err_timeout_o              sticky core-stall flag, cleared only by reset
module pico_issue_ctrl #(
   parameter int unsigned DEPTH           = 4,
   parameter int unsigned TIMEOUT         = 15,
   parameter int unsigned HOLDOFF         = 3,
   parameter bit          FLUSH_ON_BRANCH = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid_i,
   input  logic [15:0]                in_instr_i,
   output logic                       in_ready_o,
   output logic                       issue_valid_o,
   output logic [15:0]                issue_instr_o,
   input  logic                       issue_ready_i,
   input  logic                       core_done_i,
   input  logic                       core_branch_taken_i,
   output logic                       busy_o,
   output logic                       flush_pulse_o,
   output logic [$clog2(DEPTH):0]     fifo_count_o,
   output logic [7:0]                 issued_cnt_o,
   output logic                       err_timeout_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   localparam logic [CW-1:0] DepthC   = CW'(DEPTH);
   localparam logic [7:0]    TimeoutC = 8'(TIMEOUT);
   localparam logic [2:0]    HoldoffC = 3'(HOLDOFF);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StFlush} state_e;

   state_e        state_q, state_d;
   logic [15:0]   mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [2:0]    holdoff_q, holdoff_d;
   logic [7:0]    tmo_q, tmo_d;
   logic [7:0]    issued_q, issued_d;
   logic          err_q, err_d;
   logic          push, pop, clear;

   // Ready depends only on registered state, so a pop never opens a slot in the same cycle.
   assign in_ready_o    = (count_q < DepthC) && (holdoff_q == 3'd0) && (state_q != StFlush);
   assign push          = in_valid_i && in_ready_o;
   assign issue_instr_o = mem_q[rptr_q];
   assign busy_o        = (state_q != StIdle) || (count_q != '0);
   assign fifo_count_o  = count_q;
   assign issued_cnt_o  = issued_q;
   assign err_timeout_o = err_q;

   always_comb begin
      state_d       = state_q;
      tmo_d         = tmo_q;
      issued_d      = issued_q;
      err_d         = err_q;
      issue_valid_o = 1'b0;
      flush_pulse_o = 1'b0;
      pop           = 1'b0;
      clear         = 1'b0;
      holdoff_d     = (holdoff_q != 3'd0) ? holdoff_q - 3'd1 : holdoff_q;

      unique case (state_q)
         StIdle: begin
            if (count_q != '0 && holdoff_q == 3'd0) begin
               state_d = StIssue;
            end
         end
         StIssue: begin
            issue_valid_o = 1'b1;
            if (issue_ready_i) begin
               pop     = 1'b1;
               tmo_d   = 8'd0;
               state_d = StWait;
            end
         end
         StWait: begin
            tmo_d = tmo_q + 8'd1;
            // Retirement takes priority over a timeout landing in the same cycle.
            if (core_done_i) begin
               issued_d = issued_q + 8'd1;
               state_d  = (core_branch_taken_i && FLUSH_ON_BRANCH) ? StFlush : StIdle;
            end else if (tmo_d == TimeoutC) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end
         end
         StFlush: begin
            flush_pulse_o = 1'b1;
            clear         = 1'b1;
            state_d       = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (clear) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (push) wptr_d = wptr_q + AW'(1);
         if (pop)  rptr_d = rptr_q + AW'(1);
         unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
         holdoff_q <= HoldoffC;
         tmo_q     <= 8'd0;
         issued_q  <= 8'd0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         count_q   <= count_d;
         holdoff_q <= holdoff_d;
         tmo_q     <= tmo_d;
         issued_q  <= issued_d;
         err_q     <= err_d;
      end
   end

   // Storage is reset too so the head word output reads zero while in reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= 16'h0000;
      end else if (push) begin
         mem_q[wptr_q] <= in_instr_i;
      end
   end

endmodule

// File: tb/tb_pico_issue_ctrl.sv
module tb_pico_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_instr = 16'h0000;
   logic        in_ready;
   logic        issue_valid;
   logic [15:0] issue_instr;
   logic        issue_ready = 1'b0;
   logic        core_done = 1'b0;
   logic        core_branch_taken = 1'b0;
   logic        busy;
   logic        flush_pulse;
   logic [2:0]  fifo_count;
   logic [7:0]  issued_cnt;
   logic        err_timeout;

   int          n_vec = 0;
   int          n_err = 0;
   logic [7:0]  exp_cnt = 8'd0;

   pico_issue_ctrl #(
      .DEPTH(4),
      .TIMEOUT(15),
      .HOLDOFF(3),
      .FLUSH_ON_BRANCH(1'b1)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid_i(in_valid),
      .in_instr_i(in_instr),
      .in_ready_o(in_ready),
      .issue_valid_o(issue_valid),
      .issue_instr_o(issue_instr),
      .issue_ready_i(issue_ready),
      .core_done_i(core_done),
      .core_branch_taken_i(core_branch_taken),
      .busy_o(busy),
      .flush_pulse_o(flush_pulse),
      .fifo_count_o(fifo_count),
      .issued_cnt_o(issued_cnt),
      .err_timeout_o(err_timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".in_ready"},    32'(in_ready),    32'd0);
      check({tag, ".issue_valid"}, 32'(issue_valid), 32'd0);
      check({tag, ".issue_instr"}, 32'(issue_instr), 32'd0);
      check({tag, ".busy"},        32'(busy),        32'd0);
      check({tag, ".flush"},       32'(flush_pulse), 32'd0);
      check({tag, ".count"},       32'(fifo_count),  32'd0);
      check({tag, ".issued"},      32'(issued_cnt),  32'd0);
      check({tag, ".err"},         32'(err_timeout), 32'd0);
   endtask

   // Starts in IDLE with the FIFO non-empty; ends back in IDLE after one retirement.
   task automatic issue_one(input logic [15:0] w);
      step();
      check("iss.valid", 32'(issue_valid), 32'd1);
      check("iss.instr", 32'(issue_instr), 32'(w));
      issue_ready = 1'b1;
      step();
      issue_ready = 1'b0;
      check("wait.valid", 32'(issue_valid), 32'd0);
      core_done = 1'b1;
      step();
      core_done = 1'b0;
      exp_cnt = exp_cnt + 8'd1;
      check("ret.issued", 32'(issued_cnt), 32'(exp_cnt));
   endtask

   task automatic retire_one(input logic [15:0] w);
      in_valid = 1'b1;
      in_instr = w;
      step();
      in_valid = 1'b0;
      issue_one(w);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      // Reset and holdoff
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("rst");
      rst_n = 1'b1;
      in_valid = 1'b1;
      in_instr = 16'h1234;
      check("hold0", 32'(in_ready), 32'd0);
      step();
      check("hold1", 32'(in_ready), 32'd0);
      step();
      check("hold2", 32'(in_ready), 32'd0);
      step();
      check("hold.done", 32'(in_ready), 32'd1);
      check("hold.count", 32'(fifo_count), 32'd0);
      step();
      in_valid = 1'b0;
      check("push1.count", 32'(fifo_count), 32'd1);
      check("push1.busy", 32'(busy), 32'd1);
      check("push1.bubble", 32'(issue_valid), 32'd0);
      issue_one(16'h1234);
      check("t1.busy", 32'(busy), 32'd0);

      // Fill past full, pop, then accept the fifth word; order kept across wrap
      in_valid = 1'b1;
      in_instr = 16'hA000;
      step();
      in_instr = 16'hA001;
      step();
      in_instr = 16'hA002;
      step();
      in_instr = 16'hA003;
      step();
      in_instr = 16'hA004;
      check("full.count", 32'(fifo_count), 32'd4);
      check("full.ready", 32'(in_ready), 32'd0);
      check("full.head", 32'(issue_instr), 32'hA000);
      step();
      check("full.hold", 32'(fifo_count), 32'd4);
      issue_ready = 1'b1;
      check("full.pop_ready", 32'(in_ready), 32'd0);
      step();
      issue_ready = 1'b0;
      check("after_pop.count", 32'(fifo_count), 32'd3);
      check("after_pop.ready", 32'(in_ready), 32'd1);
      core_done = 1'b1;
      step();
      core_done = 1'b0;
      in_valid = 1'b0;
      exp_cnt = exp_cnt + 8'd1;
      check("push5.count", 32'(fifo_count), 32'd4);
      check("push5.issued", 32'(issued_cnt), 32'(exp_cnt));
      issue_one(16'hA001);
      issue_one(16'hA002);
      issue_one(16'hA003);
      issue_one(16'hA004);
      check("drain.count", 32'(fifo_count), 32'd0);

      // Branch-taken flush
      in_valid = 1'b1;
      in_instr = 16'hB00A;
      step();
      in_instr = 16'hB00B;
      step();
      in_instr = 16'hB00C;
      step();
      in_valid = 1'b0;
      check("fl.count", 32'(fifo_count), 32'd3);
      check("fl.head", 32'(issue_instr), 32'hB00A);
      issue_ready = 1'b1;
      step();
      issue_ready = 1'b0;
      core_done = 1'b1;
      core_branch_taken = 1'b1;
      step();
      core_done = 1'b0;
      core_branch_taken = 1'b0;
      exp_cnt = exp_cnt + 8'd1;
      check("fl.pulse", 32'(flush_pulse), 32'd1);
      check("fl.ready", 32'(in_ready), 32'd0);
      check("fl.issued", 32'(issued_cnt), 32'(exp_cnt));
      step();
      check("fl.pulse_end", 32'(flush_pulse), 32'd0);
      check("fl.empty", 32'(fifo_count), 32'd0);
      step();
      check("fl.no_issue", 32'(issue_valid), 32'd0);
      check("fl.idle_busy", 32'(busy), 32'd0);

      // Timeout after exactly 15 WAIT cycles
      in_valid = 1'b1;
      in_instr = 16'h0D0D;
      step();
      in_valid = 1'b0;
      step();
      check("to.head", 32'(issue_instr), 32'h0D0D);
      issue_ready = 1'b1;
      step();
      issue_ready = 1'b0;
      for (int i = 0; i < 14; i++) step();
      check("to.before", 32'(err_timeout), 32'd0);
      check("to.waiting", 32'(busy), 32'd1);
      step();
      check("to.err", 32'(err_timeout), 32'd1);
      check("to.idle", 32'(busy), 32'd0);
      check("to.issued", 32'(issued_cnt), 32'(exp_cnt));
      retire_one(16'h0E0E);
      check("to.sticky", 32'(err_timeout), 32'd1);

      // Counter wrap and stray done in IDLE
      while (exp_cnt != 8'd255) retire_one(16'hC000 | 16'(exp_cnt));
      check("wrap.255", 32'(issued_cnt), 32'd255);
      retire_one(16'hCFFF);
      check("wrap.0", 32'(issued_cnt), 32'd0);
      core_done = 1'b1;
      step();
      core_done = 1'b0;
      check("stray.issued", 32'(issued_cnt), 32'd0);
      check("stray.busy", 32'(busy), 32'd0);

      // Asynchronous reset mid-WAIT with 3 queued, including a simultaneous push/pop
      in_valid = 1'b1;
      in_instr = 16'hF000;
      step();
      in_instr = 16'hF001;
      step();
      in_instr = 16'hF002;
      issue_ready = 1'b1;
      step();
      issue_ready = 1'b0;
      check("pp.count", 32'(fifo_count), 32'd2);
      in_instr = 16'hF003;
      step();
      in_valid = 1'b0;
      check("mid.count", 32'(fifo_count), 32'd3);
      check("mid.busy", 32'(busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("rel.count", 32'(fifo_count), 32'd0);
      check("rel.hold0", 32'(in_ready), 32'd0);
      step();
      check("rel.hold1", 32'(in_ready), 32'd0);
      step();
      check("rel.hold2", 32'(in_ready), 32'd0);
      step();
      check("rel.ready", 32'(in_ready), 32'd1);
      check("rel.idle", 32'(issue_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
